// File: rtl/tone_pkg.sv
// tone_pkg: shared types and helpers for the tone sequencer.
//   toneState_t  - sequencer FSM state (IDLE / LOAD / PLAY)
//   entryWidth() - bit width of one note-table entry
//   divOffset()  - bit offset of voice k's divider within an entry
//   popCount()   - number of set bits in a voice vector (up to MAX_CH voices)
package tone_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } toneState_t;

  // Entry layout: duration in the low DUR_W bits, then one divider per voice.
  function automatic int entryWidth(input int nCh, input int divW, input int durW);
    return nCh * divW + durW;
  endfunction

  function automatic int divOffset(input int k, input int divW, input int durW);
    return durW + k * divW;
  endfunction

  function automatic logic [3:0] popCount(input logic [MAX_CH-1:0] bits);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clear   - forces counter and wave to 0 (used outside PLAY and on note end)
//   divider - half-period in clocks; 0 means rest (wave held low)
//   wave    - square-wave output, toggles every `divider` clocks
module tone_voice #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] divider,
  output logic             wave
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || (divider == '0)) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt == divider - ONE) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: table-driven multi-voice square-wave melody player.
//   iCLK, iRST        - clock, synchronous active-high reset
//   iWE/iWADDR/iWDATA - note table write port (accepted in any state)
//   iLEN              - number of notes to play, latched on start
//   iSTART/iSTOP      - start (sampled in IDLE) / abort playback
//   iLOOP             - replay from entry 0 when the last note ends
//   oSOUND            - 1-bit PDM mix of all voices
//   oVOICE            - raw voice square waves
//   oBUSY             - high while loading or playing
//   oIDX              - index of the current note
//   oDONE             - one-cycle pulse on natural end of sequence
//
// state | meaning
// IDLE  | waiting for iSTART with a non-zero length
// LOAD  | one clock: copy table entry into the note register, voices silent
// PLAY  | voices running, tick/duration down-counters timing the note
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int DIV_W    = 16,
  parameter int DUR_W    = 8,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 50000,
  localparam int AW      = $clog2(DEPTH),
  localparam int EW      = entryWidth(N_CH, DIV_W, DUR_W)
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iWE,
  input  logic [AW-1:0]   iWADDR,
  input  logic [EW-1:0]   iWDATA,
  input  logic [AW:0]     iLEN,
  input  logic            iSTART,
  input  logic            iSTOP,
  input  logic            iLOOP,
  output logic            oSOUND,
  output logic [N_CH-1:0] oVOICE,
  output logic            oBUSY,
  output logic [AW-1:0]   oIDX,
  output logic            oDONE
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int PH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [AW:0]       LEN_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0]     IDX_ONE   = AW'(1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(N_CH - 1);
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);

  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     rdData;
  logic [EW-1:0]     noteReg;
  logic [AW-1:0]     rdAddr;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     lastIdx;
  logic [AW:0]       lenReg;
  logic [AW:0]       lenMinus1;
  logic [TICK_W-1:0] tickCnt;
  logic [DUR_W-1:0]  durCnt;
  logic [DUR_W-1:0]  durFirst;
  logic [DUR_W-1:0]  rdDur;
  logic              noteEnd;
  logic              voiceClear;
  logic [PH_W-1:0]   ph;
  logic [3:0]        activeCnt;
  toneState_t        state;

  assign lenMinus1 = lenReg - LEN_ONE;
  assign lastIdx   = lenMinus1[AW-1:0];

  // Prefetch the entry the next LOAD will consume: entry 0 from IDLE or on
  // wrap, otherwise the following note. A write landing on the same edge as
  // the prefetch is not seen until that entry's next LOAD.
  assign rdAddr = ((state == PLAY) && (idx != lastIdx)) ? idx + IDX_ONE : '0;

  always_ff @(posedge iCLK) begin
    if (iWE) begin
      mem[iWADDR] <= iWDATA;
    end
    rdData <= mem[rdAddr];
  end

  assign rdDur    = rdData[DUR_W-1:0];
  assign durFirst = (rdDur == '0) ? '0 : rdDur - DUR_ONE;

  assign noteEnd    = (state == PLAY) && (tickCnt == '0) && (durCnt == '0);
  assign voiceClear = (state != PLAY) || iSTOP || noteEnd;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      idx     <= '0;
      lenReg  <= '0;
      noteReg <= '0;
      tickCnt <= '0;
      durCnt  <= '0;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART && !iSTOP && (iLEN != '0)) begin
            state  <= LOAD;
            idx    <= '0;
            lenReg <= iLEN;
            oBUSY  <= 1'b1;
          end
        end
        LOAD: begin
          if (iSTOP) begin
            state <= IDLE;
            idx   <= '0;
            oBUSY <= 1'b0;
          end else begin
            noteReg <= rdData;
            tickCnt <= TICK_LAST;
            durCnt  <= durFirst;
            state   <= PLAY;
          end
        end
        PLAY: begin
          if (iSTOP) begin
            state <= IDLE;
            idx   <= '0;
            oBUSY <= 1'b0;
          end else if (noteEnd) begin
            if (idx != lastIdx) begin
              idx   <= idx + IDX_ONE;
              state <= LOAD;
            end else if (iLOOP) begin
              idx   <= '0;
              state <= LOAD;
            end else begin
              idx   <= '0;
              state <= IDLE;
              oBUSY <= 1'b0;
              oDONE <= 1'b1;
            end
          end else if (tickCnt == '0) begin
            tickCnt <= TICK_LAST;
            durCnt  <= durCnt - DUR_ONE;
          end else begin
            tickCnt <= tickCnt - TICK_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

  assign oIDX = idx;

  for (genvar k = 0; k < N_CH; k++) begin : gVoice
    localparam int OFF = divOffset(k, DIV_W, DUR_W);
    tone_voice #(.DIV_W(DIV_W)) uVoice (
      .clk    (iCLK),
      .rst    (iRST),
      .clear  (voiceClear),
      .divider(noteReg[OFF +: DIV_W]),
      .wave   (oVOICE[k])
    );
  end

  assign activeCnt = popCount(MAX_CH'(oVOICE));

  // Time-sliced mix: in each N_CH-clock frame the output is high for as many
  // clocks as there are voices currently high.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ph     <= '0;
      oSOUND <= 1'b0;
    end else begin
      ph     <= (ph == PH_LAST) ? '0 : ph + PH_ONE;
      oSOUND <= (4'(ph) < activeCnt);
    end
  end

endmodule
